// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-side pull-to-stream adapter with 3-entry prefetch buffer
//
// Ports:
//   rclk      read-domain clock
//   rrst      synchronous active-high reset, shared with the read-pointer handler
//   empty     registered empty flag from the read-pointer handler
//   rdata     FIFO memory data, valid the cycle after an accepted read
//   r_en      read request to pointer handler and memory
//   m_valid   stream word available
//   m_data    stream word
//   m_ready   downstream accepts the word
//   rd_count  16-bit delivered-word counter (only with FIFO_RD_STREAM_CNT_EN)
//
// Optional feature macro: FIFO_RD_STREAM_CNT_EN
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  r_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [15:0]           rd_count
`endif
);

    logic [1:0]            cnt;
    logic                  infl;
    logic [1:0]            wp;
    logic [1:0]            rp;
    logic [DATA_WIDTH-1:0] buf_mem [0:2];

    logic [2:0]            level;
    logic                  pop;
    logic [1:0]            cnt_next;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Reserve a slot for every word already requested, so the buffer can
    // never overflow and r_en never depends on m_ready.
    assign level   = {1'b0, cnt} + {2'b00, infl};
    assign r_en    = !rrst && !empty && (level < 3'd3);

    assign m_valid = (cnt != 2'd0);
    assign m_data  = buf_mem[rp];
    assign pop     = m_valid && m_ready;

    always_comb begin
        cnt_next = cnt;
        if (infl && !pop) begin
            cnt_next = cnt + 2'd1;
        end else if (!infl && pop) begin
            cnt_next = cnt - 2'd1;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            cnt  <= 2'd0;
            infl <= 1'b0;
            wp   <= 2'd0;
            rp   <= 2'd0;
        end else begin
            cnt  <= cnt_next;
            // r_en already includes !empty, so it is exactly the accepted read.
            infl <= r_en;
            if (infl) begin
                wp <= ptr_inc(wp);
            end
            if (pop) begin
                rp <= ptr_inc(rp);
            end
        end
    end

    // Data storage needs no reset; occupancy is tracked by cnt.
    always_ff @(posedge rclk) begin
        if (!rrst && infl) begin
            buf_mem[wp] <= rdata;
        end
    end

`ifdef FIFO_RD_STREAM_CNT_EN
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rd_count <= 16'd0;
        end else if (pop) begin
            rd_count <= rd_count + 16'd1;
        end
    end
`endif

endmodule
